ntt_out_collector: RTL and testbench
====================================

Name: ntt_out_collector

Overview:
- Downstream of the NTT1024 core: captures the core's interleaved dout0 result stream after `done`.
- Applies the final conditional mod-q subtraction to each word.
- Reorders words into natural coefficient order in an internal buffer.
- Replays them to the consumer over a valid/ready interface.
- Replaces the bench-side even/odd unscramble (word m stored at index m>>1, or (m>>1)+N/2 when m is odd) with synthesizable RTL.

Parameters:
- DATA_W, 32, coefficient word width (matches dout0).
- MAX_DEPTH, 10, log2 of maximum ring size (buffer holds 1<<MAX_DEPTH words).
- ADDR_W, MAX_DEPTH, buffer address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a collection run.
- q_in  in  DATA_W  modulus, latched at start.
- ring_depth  in  4  log2 ring size, latched at start; legal range 2..MAX_DEPTH.
- ntt_done  in  1  core done flag.
- ntt_dout  in  DATA_W  core output word (dout0).
- ntt_dout_valid  in  1  qualifies ntt_dout for one cycle.
- rd_valid  out  1  rd_data/rd_index valid.
- rd_ready  in  1  consumer accepts the word when rd_valid&rd_ready.
- rd_data  out  DATA_W  reduced coefficient, natural order.
- rd_index  out  ADDR_W  coefficient index of rd_data.
- busy  out  1  high in any state except IDLE.
- run_done  out  1  one-cycle pulse after the last word is accepted.
- err_cfg  out  1  sticky: start seen with an illegal ring_depth.
- err_ovf  out  1  sticky: valid word arrived while not in COLLECT, after ntt_done.

Behaviour:
- Reset (reset==0 at clk edge):
  - State goes to IDLE.
  - All counters and the latched q and N clear.
  - rd_valid, rd_data, rd_index, busy, run_done, err_cfg and err_ovf all go to 0.
  - Buffer contents are not cleared.
  - Reset mid-run aborts the run immediately; no run_done pulse.
- States: IDLE, ARMED, COLLECT, DRAIN.
- IDLE:
  - start with 2 <= ring_depth <= MAX_DEPTH: latch q and N = 1<<ring_depth, then go to ARMED.
  - start with an illegal ring_depth: set err_cfg and stay in IDLE.
  - ntt_dout_valid is ignored.
- ARMED:
  - Wait for ntt_done==1, then go to COLLECT next cycle with word counter m=0.
  - ntt_dout_valid before ntt_done is ignored silently.
- COLLECT, on each ntt_dout_valid:
  - r = (ntt_dout >= q) ? ntt_dout - q : ntt_dout, using a single unsigned subtract.
  - Inputs are assumed below 2q; no second subtract is applied.
  - Write r to buf[addr]. addr = m>>1 if m[0]==0, else (m>>1) + N/2. m is computed in ADDR_W bits.
  - m increments by 1.
  - The write on the cycle with m==N-1 moves the state to DRAIN. Set the read pointer p=0.
  - Cycles without valid hold state.
- DRAIN:
  - Buffer read is registered, one cycle.
  - rd_valid rises no later than 2 cycles after DRAIN entry.
  - rd_data=buf[p] and rd_index=p.
  - On rd_valid&rd_ready, p increments and the next word is presented. Back-to-back acceptance gives 1 word/cycle with no bubbles (use prefetch).
  - rd_valid&~rd_ready holds rd_data and rd_index stable.
  - When the word with p==N-1 is accepted: rd_valid drops next cycle, run_done pulses 1 cycle, state goes to IDLE.
  - ntt_dout_valid in DRAIN sets err_ovf and the word is dropped.
- start while busy is ignored and has no effect on the current run.
- err_cfg and err_ovf clear only on reset.
- The read port sees only the completed buffer, so no read/write collision exists.

Test Plan:
- Depth 8, q=6556673: stream 256 words w[m]=m+1 after ntt_done.
  - Expect rd_index 0..255 in order.
  - rd_data[k] = 2k+1 for k<128 and 2(k-128)+2 for k>=128.
  - run_done pulses once.
- Reduction boundaries, q=6556673: inputs q-1, q, q+5, 2q-1.
  - Expect rd_data 6556672, 0, 5, 6556672 at their unscrambled indices.
- Backpressure at depth 4 (N=16): toggle rd_ready 1,0,0,1,...
  - rd_data and rd_index hold while stalled.
  - All 16 words are delivered once each with no duplicates or skips.
  - With rd_ready tied to 1, 16 consecutive rd_valid cycles.
- Overflow: at depth 2, send 6 valid words.
  - First 4 are collected.
  - err_ovf=1 after word 5.
  - Output equals the 4-word unscramble.
- Config and arming:
  - start with ring_depth=11: err_cfg=1, busy stays 0.
  - Valid words before ntt_done are ignored: the buffer output matches only the post-done words.
- Reset mid-COLLECT, asserted after 100 of 256 words:
  - All outputs go to 0 and state returns to IDLE.
  - A new start plus a full 256-word run produces a correct result.

Source files
------------

// File: rtl/ntt_out_collector.sv
// Captures the NTT1024 dout0 stream after done, applies the final mod-q correction,
// stores words in natural coefficient order and replays them over valid/ready.
module ntt_out_collector #(
  parameter int DATA_W    = 32,
  parameter int MAX_DEPTH = 10,
  parameter int ADDR_W    = MAX_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] q_in,
  input  logic [3:0]        ring_depth,
  input  logic              ntt_done,
  input  logic [DATA_W-1:0] ntt_dout,
  input  logic              ntt_dout_valid,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_index,
  output logic              busy,
  output logic              run_done,
  output logic              err_cfg,
  output logic              err_ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COLLECT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [3:0]      MAX_DEPTH_C = 4'(MAX_DEPTH);
  localparam logic [ADDR_W:0] ONE_N       = (ADDR_W+1)'(1);

  // Inputs are below 2q, so one subtract suffices; a borrow keeps the raw word.
  function automatic logic [DATA_W-1:0] mod_correct(input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] q);
    logic [DATA_W:0] diff;
    diff        = {1'b0, x} - {1'b0, q};
    mod_correct = diff[DATA_W] ? x : diff[DATA_W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W-1:0]   m_q, m_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_index_q, rd_index_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                busy_q, busy_d;
  logic                run_done_q, run_done_d;
  logic                err_cfg_q, err_cfg_d;
  logic                err_ovf_q, err_ovf_d;

  logic [DATA_W-1:0]   buf_mem_q [0:(1<<ADDR_W)-1];

  logic                cfg_ok_s;
  logic [ADDR_W:0]     n_cfg_s;
  logic [ADDR_W-1:0]   half_n_s;
  logic                last_wr_s;
  logic                last_rd_s;
  logic [DATA_W-1:0]   red_s;
  logic                wr_en_s;
  logic                rd_first_s;
  logic                rd_accept_s;
  logic                rd_load_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [ADDR_W-1:0]   rd_addr_s;

  assign cfg_ok_s  = (ring_depth >= 4'd2) && (ring_depth <= MAX_DEPTH_C);
  assign n_cfg_s   = ONE_N << ring_depth;
  assign half_n_s  = n_q[ADDR_W:1];
  assign last_wr_s = ({1'b0, m_q} == (n_q - ONE_N));
  assign last_rd_s = ({1'b0, rd_index_q} == (n_q - ONE_N));
  assign red_s     = mod_correct(ntt_dout, q_q);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && cfg_ok_s) state_d = ARMED;
        else                   state_d = IDLE;
      end
      ARMED: begin
        if (ntt_done) state_d = COLLECT;
        else          state_d = ARMED;
      end
      COLLECT: begin
        if (ntt_dout_valid && last_wr_s) state_d = DRAIN;
        else                             state_d = COLLECT;
      end
      DRAIN: begin
        if (rd_accept_s && last_rd_s) state_d = IDLE;
        else                          state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write/read strobes; the read address runs one ahead so accepted words refill without a bubble
  always_comb begin
    wr_en_s     = 1'b0;
    rd_first_s  = 1'b0;
    rd_accept_s = 1'b0;
    case (state_q)
      COLLECT: wr_en_s = ntt_dout_valid;
      DRAIN: begin
        rd_first_s  = ~rd_valid_q;
        rd_accept_s = rd_valid_q & rd_ready;
      end
      default: wr_en_s = 1'b0;
    endcase
    rd_load_s = rd_first_s | (rd_accept_s & ~last_rd_s);
    if (m_q[0]) wr_addr_s = (m_q >> 1) + half_n_s;
    else        wr_addr_s = m_q >> 1;
    if (rd_first_s) rd_addr_s = {ADDR_W{1'b0}};
    else            rd_addr_s = rd_index_q + ADDR_W'(1);
  end

  // Next values of the configuration, counter, output and flag registers
  always_comb begin
    q_d        = q_q;
    n_d        = n_q;
    m_d        = m_q;
    rd_valid_d = rd_valid_q;
    rd_index_d = rd_index_q;
    run_done_d = 1'b0;
    err_cfg_d  = err_cfg_q;
    err_ovf_d  = err_ovf_q;
    case (state_q)
      IDLE: begin
        if (start && cfg_ok_s) begin
          q_d = q_in;
          n_d = n_cfg_s;
        end else if (start) begin
          err_cfg_d = 1'b1;
        end else begin
          err_cfg_d = err_cfg_q;
        end
      end
      ARMED: begin
        if (ntt_done) m_d = {ADDR_W{1'b0}};
        else          m_d = m_q;
      end
      COLLECT: begin
        if (wr_en_s) m_d = m_q + ADDR_W'(1);
        else         m_d = m_q;
      end
      DRAIN: begin
        err_ovf_d = err_ovf_q | ntt_dout_valid;
        if (rd_load_s) begin
          rd_valid_d = 1'b1;
          rd_index_d = rd_addr_s;
        end else if (rd_accept_s) begin
          rd_valid_d = 1'b0;
          run_done_d = 1'b1;
        end else begin
          rd_valid_d = rd_valid_q;
        end
      end
      default: run_done_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q        <= {DATA_W{1'b0}};
      n_q        <= {(ADDR_W+1){1'b0}};
      m_q        <= {ADDR_W{1'b0}};
      rd_valid_q <= 1'b0;
      rd_index_q <= {ADDR_W{1'b0}};
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
      err_cfg_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      q_q        <= q_d;
      n_q        <= n_d;
      m_q        <= m_d;
      rd_valid_q <= rd_valid_d;
      rd_index_q <= rd_index_d;
      busy_q     <= busy_d;
      run_done_q <= run_done_d;
      err_cfg_q  <= err_cfg_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && wr_en_s) buf_mem_q[wr_addr_s] <= red_s;
  end

  // Registered buffer read feeding rd_data
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else if (rd_load_s) begin
      rd_data_q <= buf_mem_q[rd_addr_s];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_index = rd_index_q;
  assign busy     = busy_q;
  assign run_done = run_done_q;
  assign err_cfg  = err_cfg_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_ntt_out_collector.sv
// Directed bench for ntt_out_collector: a model unscrambles and reduces each driven word,
// queues the expected natural-order stream, and the read side is checked against it.
module tb_ntt_out_collector;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] Q      = 32'd6556673;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] q_in = '0;
  logic [3:0]        ring_depth = 4'd0;
  logic              ntt_done = 1'b0;
  logic [DATA_W-1:0] ntt_dout = '0;
  logic              ntt_dout_valid = 1'b0;
  logic              rd_valid;
  logic              rd_ready = 1'b1;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_index;
  logic              busy;
  logic              run_done;
  logic              err_cfg;
  logic              err_ovf;

  always #5 clk = ~clk;

  ntt_out_collector #(.DATA_W(DATA_W), .MAX_DEPTH(10), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .q_in(q_in), .ring_depth(ring_depth),
    .ntt_done(ntt_done), .ntt_dout(ntt_dout), .ntt_dout_valid(ntt_dout_valid),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_index(rd_index),
    .busy(busy), .run_done(run_done), .err_cfg(err_cfg), .err_ovf(err_ovf)
  );

  typedef struct { int idx; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          cur_streak = 0;
  int          last_streak = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [9:0]  prev_index = '0;
  logic [31:0] model_buf [0:1023];
  int          m_model = 0;
  int          n_model = 0;
  logic [31:0] q_model = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read-side monitor, called once per cycle away from the clock edge
  task automatic sample();
    exp_t e;
    if (!reset) begin
      prev_stall = 1'b0;
      cur_streak = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(rd_valid), 64'd1);
        check("hold_data", 64'(rd_data), 64'(prev_data));
        check("hold_index", 64'(rd_index), 64'(prev_index));
      end
      if (rd_valid && rd_ready) begin
        check("queue_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rd_index", 64'(rd_index), 64'(e.idx));
          check("rd_data", 64'(rd_data), 64'(e.data));
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_index = rd_index;
      if (rd_valid) begin
        cur_streak++;
      end else begin
        if (cur_streak > 0) last_streak = cur_streak;
        cur_streak = 0;
      end
      if (run_done) done_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_index", 64'(rd_index), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_run_done", 64'(run_done), 64'd0);
    check("rst_err_cfg", 64'(err_cfg), 64'd0);
    check("rst_err_ovf", 64'(err_ovf), 64'd0);
  endtask

  task automatic start_run(input logic [31:0] q, input logic [3:0] depth);
    q_in = q;
    ring_depth = depth;
    start = 1'b1;
    q_model = q;
    n_model = 1 << depth;
    m_model = 0;
    step();
    start = 1'b0;
  endtask

  task automatic arm();
    ntt_done = 1'b1;
    step();
    ntt_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rec);
    int   idx;
    exp_t e;
    ntt_dout = w;
    ntt_dout_valid = 1'b1;
    if (rec) begin
      idx = (m_model % 2 == 0) ? (m_model / 2) : (m_model / 2 + n_model / 2);
      model_buf[idx] = (w >= q_model) ? (w - q_model) : w;
      m_model++;
      if (m_model == n_model) begin
        for (int k = 0; k < n_model; k++) begin
          e.idx = k;
          e.data = model_buf[k];
          exp_q.push_back(e);
        end
      end
    end
    step();
    ntt_dout_valid = 1'b0;
  endtask

  task automatic wait_done(input bit bp, input int budget);
    int base;
    int i;
    base = done_cnt;
    i = 0;
    while (done_cnt == base && i < budget) begin
      if (bp) rd_ready = (i % 3 == 0);
      step();
      i++;
    end
    rd_ready = 1'b1;
    step();
    step();
    check("run_done_once", 64'(done_cnt - base), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("idle_after_run", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    step();
    step();
    check_reset_state();
    reset = 1'b1;
    step();

    // Illegal depth flags err_cfg and never leaves IDLE
    start_run(Q, 4'd11);
    step();
    check("cfg_err_set", 64'(err_cfg), 64'd1);
    check("cfg_not_busy", 64'(busy), 64'd0);

    // Depth 8, counting words, with pre-done words that must be ignored
    start_run(Q, 4'd8);
    check("armed_busy", 64'(busy), 64'd1);
    send_word(32'hDEAD_0001, 1'b0);
    send_word(32'hDEAD_0002, 1'b0);
    send_word(32'hDEAD_0003, 1'b0);
    arm();
    for (int m = 0; m < 256; m++) send_word(32'(m + 1), 1'b1);
    check("collect_busy", 64'(busy), 64'd1);
    wait_done(1'b0, 600);
    check("d8_streak", 64'(last_streak), 64'd256);
    check("cfg_err_sticky", 64'(err_cfg), 64'd1);

    // Reduction boundaries at N=4
    start_run(Q, 4'd2);
    arm();
    send_word(Q - 32'd1, 1'b1);
    send_word(Q, 1'b1);
    send_word(Q + 32'd5, 1'b1);
    send_word(2 * Q - 32'd1, 1'b1);
    wait_done(1'b0, 50);

    // Backpressure at N=16, then the same depth with rd_ready tied high
    start_run(Q, 4'd4);
    arm();
    for (int m = 0; m < 16; m++) send_word($urandom_range(0, 2 * Q - 1), 1'b1);
    wait_done(1'b1, 200);
    start_run(Q, 4'd4);
    arm();
    for (int m = 0; m < 16; m++) send_word($urandom_range(0, 2 * Q - 1), 1'b1);
    wait_done(1'b0, 100);
    check("d4_streak", 64'(last_streak), 64'd16);

    // Overflow: six words into a four-word run while the reader stalls
    start_run(Q, 4'd2);
    arm();
    rd_ready = 1'b0;
    for (int m = 0; m < 4; m++) send_word(32'(100 + m), 1'b1);
    check("ovf_clear_before", 64'(err_ovf), 64'd0);
    send_word(32'd200, 1'b0);
    check("ovf_set", 64'(err_ovf), 64'd1);
    send_word(32'd201, 1'b0);
    rd_ready = 1'b1;
    wait_done(1'b0, 50);
    check("ovf_sticky", 64'(err_ovf), 64'd1);

    // Reset in the middle of a collection, then a clean full run
    start_run(Q, 4'd8);
    arm();
    for (int m = 0; m < 100; m++) send_word(32'(5000 + m), 1'b0);
    reset = 1'b0;
    step();
    check_reset_state();
    reset = 1'b1;
    step();
    start_run(Q, 4'd8);
    arm();
    for (int m = 0; m < 256; m++) send_word($urandom_range(0, 2 * Q - 1), 1'b1);
    wait_done(1'b0, 600);
    check("rerun_streak", 64'(last_streak), 64'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
